// File: rtl/ro_window_counter.sv
// Ring-oscillator PUF window counter: counts synchronized rising edges of two
// ring oscillators during a measurement window and reports which one was faster.
module ro_window_counter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             window,
   input  logic             ro_a,
   input  logic             ro_b,
   input  logic             resp_ready,
   output logic             resp_valid,
   output logic             resp_bit,
   output logic             resp_tie,
   output logic             overflow,
   output logic [CNT_W-1:0] count_a,
   output logic [CNT_W-1:0] count_b,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      COMPARE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t state_reg, state_next;

   logic             window_q_reg;
   logic             window_rise;
   logic             start_meas;
   logic             count_en;
   logic             load_resp;

   logic [1:0]       ro_vec;
   logic [CNT_W-1:0] cnt_all [2];
   logic [1:0]       sat_all;

   logic             resp_bit_reg;
   logic             resp_tie_reg;
   logic [CNT_W-1:0] count_a_reg;
   logic [CNT_W-1:0] count_b_reg;

   assign ro_vec      = {ro_b, ro_a};
   assign window_rise = window & ~window_q_reg;

   // Channel 0 is oscillator A, channel 1 is oscillator B.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         logic [SYNC_STAGES-1:0] sync_reg;
         logic                   prev_reg;
         logic [CNT_W-1:0]       cnt_reg;
         logic                   sat_reg;
         logic                   rise;

         assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               sync_reg <= '0;
               prev_reg <= 1'b0;
               cnt_reg  <= '0;
               sat_reg  <= 1'b0;
            end else begin
               sync_reg <= {sync_reg[SYNC_STAGES-2:0], ro_vec[gi]};
               prev_reg <= sync_reg[SYNC_STAGES-1];
               if (start_meas) begin
                  cnt_reg <= '0;
                  sat_reg <= 1'b0;
               end else if (count_en && rise) begin
                  // Saturate instead of wrapping; the flag marks a lost edge.
                  if (cnt_reg == CNT_MAX)
                     sat_reg <= 1'b1;
                  else
                     cnt_reg <= cnt_reg + CNT_ONE;
               end
            end
         end

         assign cnt_all[gi] = cnt_reg;
         assign sat_all[gi] = sat_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         window_q_reg <= 1'b1;
         resp_bit_reg <= 1'b0;
         resp_tie_reg <= 1'b0;
         count_a_reg  <= '0;
         count_b_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         window_q_reg <= window;
         if (load_resp) begin
            resp_bit_reg <= (cnt_all[0] > cnt_all[1]);
            resp_tie_reg <= (cnt_all[0] == cnt_all[1]);
            count_a_reg  <= cnt_all[0];
            count_b_reg  <= cnt_all[1];
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      start_meas = 1'b0;
      count_en   = 1'b0;
      load_resp  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (window_rise) begin
               start_meas = 1'b1;
               state_next = MEASURE;
            end
         end
         MEASURE: begin
            if (window)
               count_en = 1'b1;
            else
               state_next = COMPARE;
         end
         COMPARE: begin
            load_resp  = 1'b1;
            state_next = HOLD;
         end
         HOLD: begin
            if (resp_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign resp_valid = (state_reg == HOLD);
   assign busy       = (state_reg != IDLE);
   assign resp_bit   = resp_bit_reg;
   assign resp_tie   = resp_tie_reg;
   assign overflow   = |sat_all;
   assign count_a    = count_a_reg;
   assign count_b    = count_b_reg;

endmodule

// File: tb/tb_ro_window_counter.sv
// Directed bench for ro_window_counter: one task per scenario, inputs driven on
// the falling edge, outputs checked on the falling edge.
module tb_ro_window_counter;

   logic        clk = 1'b0;
   logic        rst;
   logic        window;
   logic        ro_a;
   logic        ro_b;
   logic        resp_ready;

   logic        resp_valid, resp_bit, resp_tie, overflow, busy;
   logic [15:0] count_a, count_b;
   logic        v4, bit4, tie4, ovf4, busy4;
   logic [3:0]  ca4, cb4;

   int tests_run    = 0;
   int tests_failed = 0;

   int per_a = 0;
   int per_b = 0;
   bit share = 1'b0;
   int a_cnt = 0;
   int b_cnt = 0;

   always #5 clk = ~clk;

   ro_window_counter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .window(window), .ro_a(ro_a), .ro_b(ro_b),
      .resp_ready(resp_ready), .resp_valid(resp_valid), .resp_bit(resp_bit),
      .resp_tie(resp_tie), .overflow(overflow), .count_a(count_a),
      .count_b(count_b), .busy(busy)
   );

   ro_window_counter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .rst(rst), .window(window), .ro_a(ro_a), .ro_b(ro_b),
      .resp_ready(resp_ready), .resp_valid(v4), .resp_bit(bit4),
      .resp_tie(tie4), .overflow(ovf4), .count_a(ca4),
      .count_b(cb4), .busy(busy4)
   );

   // Oscillator model: toggles every per_x clocks, 2 ns after the rising edge.
   initial begin
      ro_a = 1'b0;
      ro_b = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (per_a == 0) begin
            a_cnt = 0;
            ro_a  = 1'b0;
         end else begin
            a_cnt++;
            if (a_cnt >= per_a) begin
               a_cnt = 0;
               ro_a  = ~ro_a;
            end
         end
         if (share) begin
            ro_b = ro_a;
         end else if (per_b == 0) begin
            b_cnt = 0;
            ro_b  = 1'b0;
         end else begin
            b_cnt++;
            if (b_cnt >= per_b) begin
               b_cnt = 0;
               ro_b  = ~ro_b;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_window(input int len);
      window = 1'b1;
      repeat (len) @(negedge clk);
      window = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      $display("[TB] response: valid=%0b a=%0d b=%0d bit=%0b tie=%0b ovf=%0b",
               resp_valid, count_a, count_b, resp_bit, resp_tie, overflow);
   endtask

   task automatic stop_ro();
      per_a = 0;
      per_b = 0;
      share = 1'b0;
      cycles(6);
   endtask

   task automatic handshake();
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      window     = 1'b1;
      resp_ready = 1'b0;
      cycles(3);
      tests_run++;
      if ({resp_valid, resp_bit, resp_tie, overflow, busy} !== 5'b00000) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b, expected 00000",
                  {resp_valid, resp_bit, resp_tie, overflow, busy});
      end
      tests_run++;
      if ({count_a, count_b} !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_counts: got a=%0d b=%0d, expected 0 0", count_a, count_b);
      end
      rst = 1'b0;
      // Window held high across reset release must not start a measurement.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests_run++;
         if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_window_high_busy: got %b, expected 0", busy);
         end
      end
      window = 1'b0;
      cycles(2);
      $display("[TB] reset sequence done");
   endtask

   task automatic test_a_faster();
      bit ok;
      per_a = 4;
      per_b = 6;
      pulse_window(15);
      wait_valid(ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL a_faster_valid: got %b, expected 1", resp_valid);
      end
      tests_run++;
      if ({resp_bit, resp_tie, overflow} !== 3'b100) begin
         tests_failed++;
         $display("FAIL a_faster_bit_tie_ovf: got %b, expected 100",
                  {resp_bit, resp_tie, overflow});
      end
      tests_run++;
      if ($isunknown(count_a) || int'(count_a) < 1 || int'(count_a) > 3) begin
         tests_failed++;
         $display("FAIL a_faster_count_a: got %0d, expected 2 +/-1", count_a);
      end
      tests_run++;
      if ($isunknown(count_b) || int'(count_b) > 2) begin
         tests_failed++;
         $display("FAIL a_faster_count_b: got %0d, expected 1 +/-1", count_b);
      end
      tests_run++;
      if (!(count_a > count_b)) begin
         tests_failed++;
         $display("FAIL a_faster_order: got a=%0d b=%0d, expected a > b", count_a, count_b);
      end
      handshake();
      stop_ro();
   endtask

   task automatic test_tie();
      bit ok;
      share = 1'b1;
      per_a = 4;
      pulse_window(15);
      wait_valid(ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL tie_valid: got %b, expected 1", resp_valid);
      end
      tests_run++;
      if ({resp_bit, resp_tie} !== 2'b01) begin
         tests_failed++;
         $display("FAIL tie_bit_tie: got %b, expected 01", {resp_bit, resp_tie});
      end
      tests_run++;
      if (count_a !== count_b) begin
         tests_failed++;
         $display("FAIL tie_counts_equal: got a=%0d b=%0d, expected equal", count_a, count_b);
      end
      tests_run++;
      if ($isunknown(count_a) || int'(count_a) < 1 || int'(count_a) > 3) begin
         tests_failed++;
         $display("FAIL tie_count_a: got %0d, expected 2 +/-1", count_a);
      end
      handshake();
      stop_ro();
   endtask

   task automatic test_saturate();
      bit ok;
      per_a = 2;
      pulse_window(100);
      wait_valid(ok);
      tests_run++;
      if (!ok || v4 !== 1'b1) begin
         tests_failed++;
         $display("FAIL sat_valid: got %b%b, expected 11", resp_valid, v4);
      end
      tests_run++;
      if (ca4 !== 4'd15) begin
         tests_failed++;
         $display("FAIL sat_count4: got %0d, expected 15", ca4);
      end
      tests_run++;
      if (ovf4 !== 1'b1) begin
         tests_failed++;
         $display("FAIL sat_overflow4: got %b, expected 1", ovf4);
      end
      tests_run++;
      if (cb4 !== 4'd0 || bit4 !== 1'b1) begin
         tests_failed++;
         $display("FAIL sat_b4_bit4: got b=%0d bit=%b, expected 0 1", cb4, bit4);
      end
      tests_run++;
      if ($isunknown(count_a) || int'(count_a) < 23 || int'(count_a) > 25) begin
         tests_failed++;
         $display("FAIL sat_count16: got %0d, expected 24 +/-1", count_a);
      end
      tests_run++;
      if (overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL sat_overflow16: got %b, expected 0", overflow);
      end
      handshake();
      stop_ro();
   endtask

   task automatic test_one_cycle_window();
      resp_ready = 1'b1;
      pulse_window(1);
      @(negedge clk);
      tests_run++;
      if ({resp_valid, busy} !== 2'b01) begin
         tests_failed++;
         $display("FAIL one_cycle_compare: got valid/busy %b, expected 01", {resp_valid, busy});
      end
      @(negedge clk);
      tests_run++;
      if (resp_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL one_cycle_latency: got %b, expected 1", resp_valid);
      end
      tests_run++;
      if ({resp_bit, resp_tie, overflow} !== 3'b010 || {count_a, count_b} !== 32'h0) begin
         tests_failed++;
         $display("FAIL one_cycle_result: got bit/tie/ovf %b a=%0d b=%0d, expected 010 0 0",
                  {resp_bit, resp_tie, overflow}, count_a, count_b);
      end
      $display("[TB] one-cycle window: a=%0d b=%0d tie=%0b", count_a, count_b, resp_tie);
      @(negedge clk);
      tests_run++;
      if ({resp_valid, busy} !== 2'b00) begin
         tests_failed++;
         $display("FAIL early_ready_handshake: got valid/busy %b, expected 00", {resp_valid, busy});
      end
      resp_ready = 1'b0;
      cycles(2);
   endtask

   task automatic test_back_to_back();
      bit ok;
      per_a = 4;
      pulse_window(15);
      wait_valid(ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL hold_valid: got %b, expected 1", resp_valid);
      end
      // Hold for 20 cycles with a second window pulse arriving mid-HOLD.
      for (int i = 0; i < 20; i++) begin
         if (i == 4) window = 1'b1;
         if (i == 7) window = 1'b0;
         @(negedge clk);
         tests_run++;
         if ({resp_valid, resp_bit, resp_tie, overflow, busy} !== 5'b11001) begin
            tests_failed++;
            $display("FAIL hold_flags cycle %0d: got %b, expected 11001", i,
                     {resp_valid, resp_bit, resp_tie, overflow, busy});
         end
         tests_run++;
         if ($isunknown(count_a) || int'(count_a) < 1 || int'(count_a) > 3 || count_b !== 16'd0) begin
            tests_failed++;
            $display("FAIL hold_counts cycle %0d: got a=%0d b=%0d, expected 2 +/-1 and 0",
                     i, count_a, count_b);
         end
      end
      // Window rises in the same cycle as the handshake: must not start.
      resp_ready = 1'b1;
      window     = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      tests_run++;
      if ({resp_valid, busy} !== 2'b00) begin
         tests_failed++;
         $display("FAIL handshake_busy_fall: got valid/busy %b, expected 00", {resp_valid, busy});
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rise_at_handshake_ignored cycle %0d: got %b, expected 0", i, busy);
         end
      end
      window = 1'b0;
      stop_ro();
   endtask

   task automatic test_reset_mid_measure();
      bit ok;
      per_a  = 4;
      per_b  = 6;
      window = 1'b1;
      cycles(6);
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_measure_busy: got %b, expected 1", busy);
      end
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests_run++;
         if ({resp_valid, resp_bit, resp_tie, overflow, busy} !== 5'b00000 ||
             {count_a, count_b} !== 32'h0) begin
            tests_failed++;
            $display("FAIL abort_outputs cycle %0d: got flags %b a=%0d b=%0d, expected all 0",
                     i, {resp_valid, resp_bit, resp_tie, overflow, busy}, count_a, count_b);
         end
      end
      window = 1'b0;
      stop_ro();
      per_a = 4;
      per_b = 6;
      pulse_window(15);
      wait_valid(ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL clean_restart_valid: got %b, expected 1", resp_valid);
      end
      tests_run++;
      if ({resp_bit, resp_tie, overflow} !== 3'b100) begin
         tests_failed++;
         $display("FAIL clean_restart_flags: got %b, expected 100", {resp_bit, resp_tie, overflow});
      end
      tests_run++;
      if ($isunknown({count_a, count_b}) || int'(count_a) < 1 || int'(count_a) > 3 ||
          int'(count_b) > 2) begin
         tests_failed++;
         $display("FAIL clean_restart_counts: got a=%0d b=%0d, expected 2 and 1 +/-1",
                  count_a, count_b);
      end
      handshake();
      stop_ro();
   endtask

   task automatic test_reset_in_hold();
      bit ok;
      pulse_window(1);
      wait_valid(ok);
      tests_run++;
      if (!ok || resp_tie !== 1'b1) begin
         tests_failed++;
         $display("FAIL pre_reset_hold: got valid=%b tie=%b, expected 1 1", resp_valid, resp_tie);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if ({resp_valid, resp_tie, busy} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_in_hold: got valid/tie/busy %b, expected 000",
                  {resp_valid, resp_tie, busy});
      end
      cycles(3);
      tests_run++;
      if (resp_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_in_hold_no_valid: got %b, expected 0", resp_valid);
      end
   endtask

   initial begin
      test_reset();
      test_a_faster();
      test_tie();
      test_saturate();
      test_one_cycle_window();
      test_back_to_back();
      test_reset_mid_measure();
      test_reset_in_hold();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ro_window_counter.md
RO_WINDOW_COUNTER -- requirements
Module: ro_window_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, counter and count-output width.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for ro_a/ro_b (legal range 2-4).
REQ-003 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port window  in  1  measurement window from the PUF timer ctrl output; high = measure.
REQ-006 SHALL have port ro_a  in  1  ring-oscillator A output, asynchronous to clk.
REQ-007 SHALL have port ro_b  in  1  ring-oscillator B output, asynchronous to clk.
REQ-008 SHALL have port resp_ready  in  1  consumer accepts the response.
REQ-009 SHALL have port resp_valid  out  1  response available.
REQ-010 SHALL have port resp_bit  out  1  PUF response bit, 1 = A faster than B.
REQ-011 SHALL have port resp_tie  out  1  counts were equal.
REQ-012 SHALL have port overflow  out  1  a counter saturated during the measurement.
REQ-013 SHALL have ports count_a and count_b  out  CNT_W each  final edge counts of the last measurement.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-015 SHALL pass ro_a and ro_b each through a SYNC_STAGES-flop synchronizer, then a 1-flop rising-edge detector.
REQ-016 SHALL register window into window_q and define window_rise as window & ~window_q.
REQ-017 SHALL implement the FSM states IDLE, MEASURE, COMPARE and HOLD.
REQ-018 SHALL, in IDLE on window_rise, clear both counters and overflow and go to MEASURE in the next cycle; otherwise it stays in IDLE.
REQ-019 SHALL, in MEASURE while window=1, add 1 to each counter in every cycle in which its edge detector fires; A and B are independent, so simultaneous edges increment both.
REQ-020 SHALL saturate each counter at 2^CNT_W-1 with no wrap, set overflow and keep it set until the next measurement start.
REQ-021 SHALL, in MEASURE when window=0 is sampled, go to COMPARE; any edge still inside the synchronizers is dropped.
REQ-022 SHALL, in COMPARE (one cycle), register resp_bit = (cnt_a > cnt_b), resp_tie = (cnt_a == cnt_b) and the count outputs, then go to HOLD.
REQ-023 SHALL drive resp_valid=1 in HOLD only; resp_valid rises 2 cycles after the cycle in which window=0 is first sampled in MEASURE.
REQ-024 SHALL, in HOLD, keep resp_bit, resp_tie, overflow and count_a/count_b stable until resp_valid & resp_ready, then go to IDLE in the next cycle.
REQ-025 SHALL ignore window rises in COMPARE and HOLD; a window pulse that starts before HOLD exits is not measured.
REQ-026 SHALL, on a window_rise in IDLE in the same cycle as the HOLD-exit handshake, not start a measurement, because the FSM is not in IDLE that cycle.
REQ-027 SHALL allow resp_ready to be high before resp_valid; the handshake completes in the first HOLD cycle.
REQ-028 SHALL allow a 1-cycle window (one high sample) and produce zero counts with resp_tie=1.

Reset
REQ-029 SHALL, on rst=1 at a clk edge, go to IDLE and clear all counters, synchronizer and edge flops, and resp_valid, resp_bit, resp_tie, overflow, count_a, count_b and busy.
REQ-030 SHALL reset window_q to 1 so that window held high through reset release does not start a measurement.
REQ-031 SHALL, on rst asserted mid-measurement or during HOLD, abort the measurement, discard the pending response and produce no resp_valid.
REQ-032 SHALL give rst priority over every other input in the same cycle.

Verification
REQ-033 SHALL cover: window high 15 cycles, ro_a toggles every 4 clk, ro_b every 6 clk -> resp_valid with resp_bit=1, resp_tie=0, count_a > count_b; values must match the model within +/-1 per counter for synchronizer phase.
REQ-034 SHALL cover: ro_a and ro_b driven by the same generator -> resp_tie=1, resp_bit=0.
REQ-035 SHALL cover: CNT_W=4 with ro_a toggling every 2 clk for 100 cycles -> count_a=15, overflow=1.
REQ-036 SHALL cover: resp_ready held low 20 cycles then pulsed -> outputs stable throughout, a second window pulse during HOLD is ignored, and busy falls 1 cycle after the handshake.
REQ-037 SHALL cover: rst pulsed mid-MEASURE, and window high across reset release -> no resp_valid, all outputs 0, and the next true rising edge starts a clean measurement.
